// File: rtl/motion_mask_pkg.sv
// Shared types, mask constants and arithmetic helpers for the motion mask pipeline.
// The optional foreground statistics are enabled with MOTION_MASK_STATS_EN.
package motion_mask_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   localparam logic [23:0] MASK_FG = 24'hFFFFFF;
   localparam logic [23:0] MASK_BG = 24'h000000;

   localparam int unsigned SUM_W    = 10;
   localparam int unsigned FG_CNT_W = 20;

   // Max minus min, so the result never wraps.
   function automatic logic [7:0] absdiff8(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] res;
      if (a > b) begin
         res = a - b;
      end else begin
         res = b - a;
      end
      return res;
   endfunction

   function automatic logic [SUM_W-1:0] sum3(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c);
      return {2'b00, a} + {2'b00, b} + {2'b00, c};
   endfunction

endpackage

// File: rtl/pixel_diff_sum.sv
// Two-stage datapath: per-channel absolute difference, then the 10-bit channel sum.
// Both stages load only when en is high, so a stalled pipeline holds its contents.
module pixel_diff_sum
   import motion_mask_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   input  logic                en,
   input  logic [23:0]         ped,
   input  logic [23:0]         bg,
   output logic [SUM_W-1:0]    sum
);

   pixel_t ped_px;
   pixel_t bg_px;

   logic [7:0]       dr_q, dg_q, db_q;
   logic [7:0]       dr_d, dg_d, db_d;
   logic [SUM_W-1:0] sum_q, sum_d;

   always_comb begin
      ped_px = pixel_t'(ped);
      bg_px  = pixel_t'(bg);
      dr_d   = absdiff8(ped_px.r, bg_px.r);
      dg_d   = absdiff8(ped_px.g, bg_px.g);
      db_d   = absdiff8(ped_px.b, bg_px.b);
      sum_d  = sum3(dr_q, dg_q, db_q);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         dr_q  <= '0;
         dg_q  <= '0;
         db_q  <= '0;
         sum_q <= '0;
      end else if (en) begin
         dr_q  <= dr_d;
         dg_q  <= dg_d;
         db_q  <= db_d;
         sum_q <= sum_d;
      end
   end

   assign sum = sum_q;

endmodule

// File: rtl/motion_mask.sv
// Background-subtraction mask: pops live and background FWFT FIFOs in lockstep and writes
// a full-white/black mask per pixel. Define MOTION_MASK_STATS_EN to add the fg_count port.
module motion_mask
   import motion_mask_pkg::*;
#(
   parameter int unsigned WIDTH     = 768,
   parameter int unsigned HEIGHT    = 576,
   parameter logic [9:0]  THRESHOLD = 10'd60
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [23:0] in_dout_ped,
   input  logic        in_empty_ped,
   output logic        in_rd_en_ped,
   input  logic [23:0] in_dout_bg,
   input  logic        in_empty_bg,
   output logic        in_rd_en_bg,
   output logic [23:0] out_din,
   input  logic        out_full,
   output logic        out_wr_en,
   output logic        frame_done
`ifdef MOTION_MASK_STATS_EN
   ,
   output logic [FG_CNT_W-1:0] fg_count
`endif
);

   localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   logic             adv;
   logic             take;
   logic             s1_valid_q;
   logic             s2_valid_q;
   logic [SUM_W-1:0] s2_sum;
   logic             is_fg;

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             col_last;
   logic             row_last;
   logic             frame_start;
   logic             frame_done_q, frame_done_d;

   // A full output FIFO only blocks the pipeline when stage 2 actually holds a pixel.
   assign adv  = !(s2_valid_q && out_full);
   assign take = adv && !in_empty_ped && !in_empty_bg;

   assign in_rd_en_ped = take;
   assign in_rd_en_bg  = take;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
      end else if (adv) begin
         s1_valid_q <= take;
         s2_valid_q <= s1_valid_q;
      end
   end

   pixel_diff_sum u_pixel_diff_sum (
      .clock (clock),
      .reset (reset),
      .en    (adv),
      .ped   (in_dout_ped),
      .bg    (in_dout_bg),
      .sum   (s2_sum)
   );

   assign is_fg     = (s2_sum > THRESHOLD);
   assign out_din   = is_fg ? MASK_FG : MASK_BG;
   assign out_wr_en = s2_valid_q && !out_full;

   assign col_last    = (col_q == COL_W'(WIDTH - 1));
   assign row_last    = (row_q == ROW_W'(HEIGHT - 1));
   assign frame_start = (col_q == '0) && (row_q == '0);

   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      frame_done_d = 1'b0;
      if (out_wr_en) begin
         if (col_last) begin
            col_d = '0;
            if (row_last) begin
               row_d        = '0;
               frame_done_d = 1'b1;
            end else begin
               row_d = row_q + ROW_W'(1);
            end
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col_q        <= '0;
         row_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign frame_done = frame_done_q;

`ifdef MOTION_MASK_STATS_EN
   logic [FG_CNT_W-1:0] fg_q, fg_d;

   // The first write of a frame restarts the tally; otherwise the last total is held.
   always_comb begin
      fg_d = fg_q;
      if (out_wr_en) begin
         if (frame_start) begin
            fg_d = {{(FG_CNT_W-1){1'b0}}, is_fg};
         end else begin
            fg_d = fg_q + {{(FG_CNT_W-1){1'b0}}, is_fg};
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fg_q <= '0;
      end else begin
         fg_q <= fg_d;
      end
   end

   assign fg_count = fg_q;
`else
   logic unused_frame_start;
   assign unused_frame_start = frame_start;
`endif

endmodule

// File: tb/tb_motion_mask.sv
// Self-checking bench for motion_mask with a small 4x2 frame; a queue-based reference model
// predicts pops, mask values, frame boundaries and (when MOTION_MASK_STATS_EN) fg_count.
module tb_motion_mask;

   localparam int unsigned W     = 4;
   localparam int unsigned H     = 2;
   localparam int unsigned FRAME = W * H;
   localparam int          THR   = 60;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [23:0] in_dout_ped = '0;
   logic        in_empty_ped = 1'b1;
   logic        in_rd_en_ped;
   logic [23:0] in_dout_bg = '0;
   logic        in_empty_bg = 1'b1;
   logic        in_rd_en_bg;
   logic [23:0] out_din;
   logic        out_full = 1'b0;
   logic        out_wr_en;
   logic        frame_done;
`ifdef MOTION_MASK_STATS_EN
   logic [19:0] fg_count;
`endif

   motion_mask #(
      .WIDTH     (W),
      .HEIGHT    (H),
      .THRESHOLD (10'd60)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_dout_ped  (in_dout_ped),
      .in_empty_ped (in_empty_ped),
      .in_rd_en_ped (in_rd_en_ped),
      .in_dout_bg   (in_dout_bg),
      .in_empty_bg  (in_empty_bg),
      .in_rd_en_bg  (in_rd_en_bg),
      .out_din      (out_din),
      .out_full     (out_full),
      .out_wr_en    (out_wr_en),
      .frame_done   (frame_done)
`ifdef MOTION_MASK_STATS_EN
      ,
      .fg_count     (fg_count)
`endif
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   logic [23:0] qp[$];
   logic [23:0] qb[$];
   logic [23:0] qe[$];
   int inflight  = 0;
   int pos       = 0;
   int fg_model  = 0;
   int cyc       = 0;
   int first_pop = -1;
   int first_wr  = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: sum of per-channel |difference|, foreground when strictly above threshold.
   function automatic logic [23:0] ref_mask(input logic [23:0] p, input logic [23:0] b);
      int s;
      int a;
      int c;
      s = 0;
      for (int k = 0; k < 3; k++) begin
         a = int'((p >> (8 * k)) & 24'hFF);
         c = int'((b >> (8 * k)) & 24'hFF);
         s += (a > c) ? (a - c) : (c - a);
      end
      return (s > THR) ? 24'hFFFFFF : 24'h000000;
   endfunction

   task automatic push_random_pair();
      logic [23:0] b;
      logic [23:0] p;
      int ch;
      b = 24'($urandom);
      if ($urandom_range(0, 1) == 1) begin
         p = 24'($urandom);
      end else begin
         p = '0;
         for (int k = 0; k < 3; k++) begin
            ch = int'((b >> (8 * k)) & 24'hFF) + int'($urandom_range(0, 50)) - 25;
            if (ch < 0) ch = 0;
            if (ch > 255) ch = 255;
            p = p | (24'(ch) << (8 * k));
         end
      end
      qp.push_back(p);
      qb.push_back(b);
   endtask

   // One clock: present FIFO heads, sample outputs mid-cycle, update the model at the edge.
   task automatic step(input logic full);
      logic rd;
      logic wr;
      logic [23:0] din;
      logic [23:0] exp_m;
      logic fd_exp;
      logic both;
      both         = (qp.size() > 0) && (qb.size() > 0);
      in_empty_ped = (qp.size() == 0);
      in_empty_bg  = (qb.size() == 0);
      in_dout_ped  = in_empty_ped ? 24'h0 : qp[0];
      in_dout_bg   = in_empty_bg ? 24'h0 : qb[0];
      out_full     = full;
      #1;
      rd  = in_rd_en_ped;
      wr  = out_wr_en;
      din = out_din;
      chk("rd_lockstep", in_rd_en_bg, rd);
      if (!both) chk("rd_without_both", rd, 0);
      else if (!full) chk("rd_when_ready", rd, 1);
      if (full && inflight == 2) chk("rd_during_stall", rd, 0);
      if (full) chk("wr_while_full", wr, 0);
      @(posedge clock);
      cyc++;
      fd_exp = 1'b0;
      if (wr) begin
         if (qe.size() == 0) begin
            chk("wr_unexpected", wr, 0);
         end else begin
            exp_m = qe.pop_front();
            chk("mask", din, exp_m);
            inflight--;
            if (first_wr < 0) first_wr = cyc;
            if (pos == 0) fg_model = 0;
            if (exp_m == 24'hFFFFFF) fg_model++;
            pos++;
            if (pos == FRAME) begin
               pos    = 0;
               fd_exp = 1'b1;
            end
         end
      end
      if (rd && both) begin
         qe.push_back(ref_mask(qp.pop_front(), qb.pop_front()));
         inflight++;
         if (first_pop < 0) first_pop = cyc;
      end
      #1;
      chk("frame_done", frame_done, fd_exp);
`ifdef MOTION_MASK_STATS_EN
      chk("fg_count", fg_count, fg_model);
`endif
      @(negedge clock);
   endtask

   task automatic drain(input int max_cycles);
      int n;
      n = 0;
      while (((qp.size() > 0 && qb.size() > 0) || inflight > 0) && n < max_cycles) begin
         step(1'b0);
         n++;
      end
      chk("drain_in_time", n < max_cycles, 1);
   endtask

   task automatic do_reset();
      in_empty_ped = 1'b1;
      in_empty_bg  = 1'b1;
      out_full     = 1'b0;
      reset        = 1'b0;
      #1;
      chk("rst_wr_en", out_wr_en, 0);
      chk("rst_rd_en", in_rd_en_ped, 0);
      chk("rst_din", out_din, 0);
      chk("rst_frame_done", frame_done, 0);
`ifdef MOTION_MASK_STATS_EN
      chk("rst_fg_count", fg_count, 0);
`endif
      qe.delete();
      inflight = 0;
      pos      = 0;
      fg_model = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      @(negedge clock);
      do_reset();

      // Equal pixels: background mask, two-cycle pop-to-write latency.
      repeat (4) begin
         qp.push_back(24'h808080);
         qb.push_back(24'h808080);
      end
      drain(50);
      chk("latency", first_wr - first_pop, 2);

      // Threshold boundary and channel order; these four complete the first frame.
      qp.push_back(24'hFF0000); qb.push_back(24'h000000);
      qp.push_back(24'h141414); qb.push_back(24'h000000);
      qp.push_back(24'h141415); qb.push_back(24'h000000);
      qp.push_back(24'h000000); qb.push_back(24'h151414);
      drain(50);

      // Only the live FIFO has data: nothing may be popped or written.
      repeat (10) qp.push_back(24'($urandom));
      repeat (10) step(1'b0);
      chk("ped_untouched", qp.size(), 10);
      chk("nothing_in_flight", inflight, 0);
      repeat (10) qb.push_back(24'($urandom));
      drain(60);

      // Continuous stream with a forced 5-cycle stall plus random back-pressure.
      repeat (40) push_random_pair();
      n = 0;
      while ((qp.size() > 0 || inflight > 0) && n < 400) begin
         if (n >= 6 && n < 11) step(1'b1);
         else step($urandom_range(0, 3) == 0);
         n++;
      end
      chk("stream_in_time", n < 400, 1);
      chk("stream_no_loss", qe.size(), 0);

      // Reset mid-frame with two pixels in flight, then a full fresh frame.
      repeat (12) push_random_pair();
      n = 0;
      while (!(pos >= 3 && inflight == 2) && n < 30) begin
         step(1'b0);
         n++;
      end
      chk("two_in_flight", inflight, 2);
      do_reset();
      repeat (8) push_random_pair();
      drain(100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
